pkt_rx_arb: RTL and testbench
=============================

Name: pkt_rx_arb

Overview:
- Receive-side endpoint of the row/column packet fabric: one instance per node per direction.
- Terminates the N_IN point-to-point channels arriving from the other nodes in the same row or column, after their IRS pipeline stages.
- Buffers each channel, drops misrouted packets, and merges the rest onto one valid/ready stream into the node core.
- Arbitration is QoS-priority round-robin with an anti-starvation guard for low-QoS traffic.

Parameters:
- N_IN, 7, number of incoming channels (peer nodes on the line).
- TYPE_W, 2, packet type width.
- ID_W, 6, node ID width (64 nodes).
- FLIT_W, 32, payload width.
- NODE_ID, 0, this node's ID; packets whose tgt differs are misrouted.
- STARVE_LIM, 4, maximum consecutive qos=1 grants while any qos=0 head waits.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_vld  in  N_IN  per-channel valid
- in_rdy  out  N_IN  per-channel ready
- in_qos  in  N_IN  per-channel QoS bit (1 = high)
- in_type  in  N_IN*TYPE_W  packed, channel i at [i*TYPE_W +: TYPE_W]
- in_src  in  N_IN*ID_W  packed source IDs
- in_tgt  in  N_IN*ID_W  packed target IDs
- in_data  in  N_IN*FLIT_W  packed payloads
- out_vld  out  1  packet valid to node core
- out_rdy  in  1  node core ready
- out_qos  out  1  granted packet QoS
- out_type  out  TYPE_W  granted packet type
- out_src  out  ID_W  granted packet source
- out_tgt  out  ID_W  granted packet target
- out_data  out  FLIT_W  granted packet payload
- out_port  out  clog2(N_IN)  index of the channel the packet came from
- err_misroute  out  1  sticky misroute flag
- err_cnt  out  16  saturating count of dropped misrouted packets

Behaviour:
- Reset (clk edge with rst_n=0):
  - All FIFOs empty; in_rdy = 0 during reset, then all 1 from the first cycle after rst_n=1.
  - out_vld=0 and all out_* fields 0.
  - Both RR pointers = 0; starvation counter = 0; err_misroute=0; err_cnt=0.
  - Reset mid-operation discards all buffered and in-flight packets; no partial output.
- Input buffering:
  - Each channel has a 2-entry FIFO.
  - in_rdy[i] = FIFO i not full. It is registered and depends only on state, never on in_vld.
  - A handshake (vld & rdy) pushes {qos,type,src,tgt,data}.
  - Full throughput: 1 packet/cycle/channel if drained.
  - A push and a pop in the same cycle on a full FIFO is not allowed, because rdy=0 when full.
- Misroute drop:
  - If a FIFO head has tgt != NODE_ID, it is popped that cycle and is not eligible for grant.
  - Any drop sets err_misroute.
  - err_cnt += number of drops that cycle, saturating at 16'hFFFF.
- Eligibility: non-empty FIFO whose head has tgt == NODE_ID.
- Output register:
  - Loads when out_vld==0 or (out_vld & out_rdy).
  - Loads the winner if any input is eligible, else out_vld←0.
  - When out_vld=1 and out_rdy=0, all out_* hold stable.
- Arbitration, evaluated only in load cycles:
  - Class selection:
    - If any eligible head has qos=1 and starve counter < STARVE_LIM, select class 1.
    - Else if any eligible head has qos=0, select class 0.
    - Else select class 1.
  - Within a class: round-robin starting at that class's pointer, searching upward with wrap at N_IN.
  - Winner i is popped; out_port=i; that class's pointer ← (i+1) mod N_IN. The other class's pointer is unchanged.
  - Starve counter:
    - Increments when class 1 is granted while a qos=0 eligible head exists.
    - Resets to 0 on any class 0 grant, or when no qos=0 head is eligible.
- Latency: in handshake at cycle T → earliest out_vld at T+2.
- Throughput: 1 packet/cycle sustained on out.
- Ordering: per-channel order is preserved; there is no ordering between channels.

Test Plan:
- Reset then single packet:
  - Stimulus: ch3 sends qos=0, tgt=NODE_ID, data=0xA5A5_0001 at T.
  - Required: out_vld at T+2 with out_port=3, same fields; in_rdy=7'h7F after reset.
- Round-robin:
  - Stimulus: all 7 channels hold qos=0 packets continuously, out_rdy=1.
  - Required: out_port sequence 0,1,2,3,4,5,6,0,…; one packet/cycle.
- QoS with anti-starvation, STARVE_LIM=4:
  - Stimulus: ch1 qos=1 stream, ch5 qos=0 stream.
  - Required: out_port pattern 1,1,1,1,5,1,1,1,1,5,…
- Backpressure:
  - Stimulus: out_rdy=0 for 10 cycles with ch0 streaming.
  - Required: out_* stable; in_rdy[0] deasserts after 2 accepts beyond the output register; no loss or duplication after release.
- Misroute:
  - Stimulus: ch2 sends 3 packets with tgt=NODE_ID+1 interleaved with 2 good packets.
  - Required: only the 2 good packets are output, in order; err_cnt=3; err_misroute=1.
- Mid-traffic reset:
  - Stimulus: rst_n low for 1 cycle while FIFOs are partly full and out_vld=1.
  - Required: next cycle out_vld=0, err_cnt=0; no stale packet emitted afterward.

Source files
------------

// File: rtl/pkt_rx_arb.sv
// pkt_rx_arb: receive endpoint for one line (row or column) of the packet fabric.
// Each incoming channel is buffered in a 2-deep FIFO. Heads not addressed to
// NODE_ID are dropped and counted. The remaining heads are merged onto one output
// register. Merging uses QoS-priority round-robin, and a starvation guard limits
// how long qos=0 traffic can be held off.
//
// Handshake: on every port a transfer happens on a rising clk edge where vld and
// rdy are both 1. in_rdy is a register that depends only on FIFO occupancy and
// never on in_vld. While out_vld=1 and out_rdy=0, out_vld and all out_* fields
// hold steady.
module pkt_rx_arb #(
    parameter int N_IN       = 7,
    parameter int TYPE_W     = 2,
    parameter int ID_W       = 6,
    parameter int FLIT_W     = 32,
    parameter int NODE_ID    = 0,
    parameter int STARVE_LIM = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         in_vld,
    output logic [N_IN-1:0]         in_rdy,
    input  logic [N_IN-1:0]         in_qos,
    input  logic [N_IN*TYPE_W-1:0]  in_type,
    input  logic [N_IN*ID_W-1:0]    in_src,
    input  logic [N_IN*ID_W-1:0]    in_tgt,
    input  logic [N_IN*FLIT_W-1:0]  in_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    out_qos,
    output logic [TYPE_W-1:0]       out_type,
    output logic [ID_W-1:0]         out_src,
    output logic [ID_W-1:0]         out_tgt,
    output logic [FLIT_W-1:0]       out_data,
    output logic [$clog2(N_IN)-1:0] out_port,
    output logic                    err_misroute,
    output logic [15:0]             err_cnt
);

    localparam int PW = $clog2(N_IN);
    localparam int EW = 1 + TYPE_W + 2 * ID_W + FLIT_W;
    localparam int SW = $clog2(STARVE_LIM + 2);
    // Entry layout, MSB first: {qos, type, src, tgt, data}
    localparam int TGT_LSB  = FLIT_W;
    localparam int SRC_LSB  = FLIT_W + ID_W;
    localparam int TYPE_LSB = FLIT_W + 2 * ID_W;

    logic [EW-1:0]   mem      [N_IN][2];
    logic [1:0]      cnt      [N_IN];
    logic [1:0]      cnt_next [N_IN];
    logic [EW-1:0]   entry_in [N_IN];
    logic [EW-1:0]   head     [N_IN];
    logic [N_IN-1:0] wr_ptr, rd_ptr;
    logic [N_IN-1:0] head_qos, head_ok, nonempty, elig, drop, push, pop, cand;
    logic            any_q1, any_q0, sel_cls, found, load, grant;
    logic [PW-1:0]   ptr0, ptr1, start, idx, win, next_ptr;
    logic [EW-1:0]   win_ent;
    logic [SW-1:0]   starve;
    logic [16:0]     err_sum;

    // Pack incoming fields and classify each FIFO head as eligible or misrouted
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            entry_in[i] = {in_qos[i], in_type[i*TYPE_W +: TYPE_W], in_src[i*ID_W +: ID_W],
                           in_tgt[i*ID_W +: ID_W], in_data[i*FLIT_W +: FLIT_W]};
            head[i]     = mem[i][rd_ptr[i]];
            nonempty[i] = (cnt[i] != 2'd0);
            head_qos[i] = head[i][EW-1];
            head_ok[i]  = (head[i][TGT_LSB +: ID_W] == ID_W'(NODE_ID));
            elig[i]     = nonempty[i] & head_ok[i];
            drop[i]     = nonempty[i] & ~head_ok[i];
            push[i]     = in_vld[i] & in_rdy[i];
        end
    end

    // Pick a QoS class, then round-robin within it from that class's pointer
    always_comb begin
        any_q1 = |(elig & head_qos);
        any_q0 = |(elig & ~head_qos);
        if (any_q1 && (starve < SW'(STARVE_LIM))) sel_cls = 1'b1;
        else if (any_q0)                          sel_cls = 1'b0;
        else                                      sel_cls = 1'b1;
        cand    = elig & (sel_cls ? head_qos : ~head_qos);
        start   = sel_cls ? ptr1 : ptr0;
        found   = 1'b0;
        win     = '0;
        win_ent = '0;
        idx     = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = PW'((int'(start) + k) % N_IN);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win     = idx;
                win_ent = head[idx];
            end
        end
        next_ptr = (win == PW'(N_IN - 1)) ? '0 : win + PW'(1);
        load     = ~out_vld | out_rdy;
        grant    = load & found;
        for (int i = 0; i < N_IN; i++) begin
            pop[i]      = drop[i] | (grant & (win == PW'(i)));
            cnt_next[i] = cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
        end
        err_sum = {1'b0, err_cnt} + 17'($countones(drop));
    end

    // FIFO pointers and occupancy; in_rdy is registered from next occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_rdy <= '0;
            for (int i = 0; i < N_IN; i++) cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
                if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
                cnt[i]    <= cnt_next[i];
                in_rdy[i] <= (cnt_next[i] != 2'd2);
            end
        end
    end

    // FIFO storage; slot contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= entry_in[i];
        end
    end

    // Output register: refill on an empty or draining slot, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_qos  <= 1'b0;
            out_type <= '0;
            out_src  <= '0;
            out_tgt  <= '0;
            out_data <= '0;
            out_port <= '0;
        end else if (load) begin
            out_vld <= found;
            if (found) begin
                out_qos  <= win_ent[EW-1];
                out_type <= win_ent[TYPE_LSB +: TYPE_W];
                out_src  <= win_ent[SRC_LSB +: ID_W];
                out_tgt  <= win_ent[TGT_LSB +: ID_W];
                out_data <= win_ent[FLIT_W-1:0];
                out_port <= win;
            end
        end
    end

    // Arbiter pointers, starvation counter and misroute error tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr0         <= '0;
            ptr1         <= '0;
            starve       <= '0;
            err_misroute <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (grant) begin
                if (sel_cls) ptr1 <= next_ptr;
                else         ptr0 <= next_ptr;
            end
            // The counter only measures waiting qos=0 heads; it clears once none wait
            if (!any_q0)    starve <= '0;
            else if (grant) starve <= sel_cls ? starve + SW'(1) : '0;
            if (|drop) err_misroute <= 1'b1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

// File: tb/tb_pkt_rx_arb.sv
// Testbench for pkt_rx_arb: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the receive endpoint.
module tb_pkt_rx_arb;

    localparam int N_IN = 7, TYPE_W = 2, ID_W = 6, FLIT_W = 32;
    localparam int NODE_ID = 0, STARVE_LIM = 4;
    localparam int PW = 3;
    localparam int EW = 1 + TYPE_W + 2 * ID_W + FLIT_W;
    localparam logic [ID_W-1:0] GOOD = ID_W'(NODE_ID);
    localparam logic [ID_W-1:0] BAD  = ID_W'(NODE_ID + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_IN-1:0]        in_vld, in_rdy, in_qos;
    logic [N_IN*TYPE_W-1:0] in_type;
    logic [N_IN*ID_W-1:0]   in_src, in_tgt;
    logic [N_IN*FLIT_W-1:0] in_data;
    logic                   out_vld, out_rdy, out_qos;
    logic [TYPE_W-1:0]      out_type;
    logic [ID_W-1:0]        out_src, out_tgt;
    logic [FLIT_W-1:0]      out_data;
    logic [PW-1:0]          out_port;
    logic                   err_misroute;
    logic [15:0]            err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Values sampled just before each active edge
    logic [N_IN-1:0]   pre_rdy, last_hs;
    logic              got_vld;
    logic [FLIT_W-1:0] got_data;
    logic [PW-1:0]     got_port;
    logic [FLIT_W-1:0] exp_q[$];

    // Reference model state
    logic [EW-1:0]   mq [N_IN][$];
    logic [N_IN-1:0] m_rdy;
    logic            m_vld;
    logic [EW-1:0]   m_out;
    logic [PW-1:0]   m_port;
    int              m_ptr [2];
    int              m_starve;
    logic            m_err;
    logic [15:0]     m_cnt;

    pkt_rx_arb #(
        .N_IN(N_IN), .TYPE_W(TYPE_W), .ID_W(ID_W), .FLIT_W(FLIT_W),
        .NODE_ID(NODE_ID), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_qos(in_qos), .in_type(in_type),
        .in_src(in_src), .in_tgt(in_tgt), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_qos(out_qos), .out_type(out_type),
        .out_src(out_src), .out_tgt(out_tgt), .out_data(out_data), .out_port(out_port),
        .err_misroute(err_misroute), .err_cnt(err_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached after checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // Reference model: one clock edge of the endpoint, computed from the queues
    task automatic model_edge();
        logic [N_IN-1:0] el, dr, hq;
        logic any1, any0, cls, ld;
        int w, id;
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) mq[i].delete();
            m_rdy = '0; m_vld = 1'b0; m_out = '0; m_port = '0;
            m_ptr[0] = 0; m_ptr[1] = 0; m_starve = 0; m_err = 1'b0; m_cnt = '0;
            return;
        end
        el = '0; dr = '0; hq = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (mq[i].size() > 0) begin
                hq[i] = mq[i][0][EW-1];
                if (mq[i][0][FLIT_W +: ID_W] == GOOD) el[i] = 1'b1;
                else                                  dr[i] = 1'b1;
            end
        end
        any1 = |(el & hq);
        any0 = |(el & ~hq);
        cls  = (any1 && m_starve < STARVE_LIM) ? 1'b1 : (any0 ? 1'b0 : 1'b1);
        ld   = !m_vld || out_rdy;
        w    = -1;
        if (ld) begin
            for (int k = 0; k < N_IN; k++) begin
                id = (m_ptr[cls] + k) % N_IN;
                if (w < 0 && el[id] && hq[id] == cls) w = id;
            end
        end
        if (!any0)       m_starve = 0;
        else if (w >= 0) m_starve = cls ? m_starve + 1 : 0;
        for (int i = 0; i < N_IN; i++) begin
            if (dr[i]) begin
                m_err = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        if (ld) begin
            if (w >= 0) begin
                m_vld = 1'b1; m_out = mq[w][0]; m_port = PW'(w);
                m_ptr[cls] = (w + 1) % N_IN;
            end else begin
                m_vld = 1'b0;
            end
        end
        for (int i = 0; i < N_IN; i++) if (dr[i] || i == w) void'(mq[i].pop_front());
        for (int i = 0; i < N_IN; i++) begin
            if (in_vld[i] && m_rdy[i])
                mq[i].push_back({in_qos[i], in_type[i*TYPE_W +: TYPE_W], in_src[i*ID_W +: ID_W],
                                 in_tgt[i*ID_W +: ID_W], in_data[i*FLIT_W +: FLIT_W]});
        end
        for (int i = 0; i < N_IN; i++) m_rdy[i] = (mq[i].size() < 2);
    endtask

    // Driver: advance one clock, sampling handshakes before the edge
    task automatic step();
        pre_rdy  = in_rdy;
        got_vld  = out_vld & out_rdy;
        got_data = out_data;
        got_port = out_port;
        @(posedge clk);
        last_hs = in_vld & pre_rdy;
        model_edge();
        #1;
    endtask

    task automatic set_ch(input int i, input logic q, input logic [ID_W-1:0] t, input logic [FLIT_W-1:0] d);
        in_qos[i] = q;
        in_type[i*TYPE_W +: TYPE_W] = TYPE_W'($urandom);
        in_src[i*ID_W +: ID_W]      = ID_W'($urandom);
        in_tgt[i*ID_W +: ID_W]      = t;
        in_data[i*FLIT_W +: FLIT_W] = d;
    endtask

    // Give every channel that was just accepted a fresh payload
    task automatic refresh();
        for (int i = 0; i < N_IN; i++) if (last_hs[i]) in_data[i*FLIT_W +: FLIT_W] = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_vld = '0; out_rdy = 1'b1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_rdy = 1'b0;
        step(); step();
        n_checks++; if (in_rdy !== 7'h00) begin n_fail++; $display("FAIL reset_in_rdy got=%h exp=00", in_rdy); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        n_checks++;
        if ({out_qos, out_type, out_src, out_tgt, out_data, out_port} !== '0) begin
            n_fail++; $display("FAIL reset_out_fields got=%h exp=0", {out_qos, out_type, out_src, out_tgt, out_data, out_port});
        end
        n_checks++;
        if (err_misroute !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_err got=%b/%0d exp=0/0", err_misroute, err_cnt);
        end
        rst_n = 1'b1;
        step();
        n_checks++; if (in_rdy !== 7'h7F) begin n_fail++; $display("FAIL post_reset_in_rdy got=%h exp=7f", in_rdy); end
    endtask

    task automatic test_single();
        out_rdy = 1'b1;
        set_ch(3, 1'b0, GOOD, 32'hA5A5_0001);
        in_type[7:6] = 2'd2;
        in_src[23:18] = 6'd9;
        in_vld = 7'b0001000;
        step();
        in_vld = '0;
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_t1_vld got=%b exp=0", out_vld); end
        step();
        n_checks++;
        if (out_vld !== 1'b1 || out_port !== 3'd3) begin
            n_fail++; $display("FAIL single_t2 got vld=%b port=%0d exp vld=1 port=3", out_vld, out_port);
        end
        n_checks++;
        if ({out_qos, out_type, out_src, out_tgt, out_data} !== {1'b0, 2'd2, 6'd9, GOOD, 32'hA5A5_0001}) begin
            n_fail++; $display("FAIL single_fields got=%b/%0d/%0d/%0d/%h", out_qos, out_type, out_src, out_tgt, out_data);
        end
        step();
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", out_vld); end
    endtask

    task automatic test_round_robin();
        int exp_port;
        do_reset();
        for (int i = 0; i < N_IN; i++) set_ch(i, 1'b0, GOOD, $urandom);
        in_vld = '1; exp_port = 0;
        for (int c = 0; c < 36; c++) begin
            step();
            refresh();
            if (c >= 1) begin
                n_checks++;
                if (out_vld !== 1'b1 || out_port !== PW'(exp_port)) begin
                    n_fail++; $display("FAIL rr_seq c=%0d got vld=%b port=%0d exp port=%0d", c, out_vld, out_port, exp_port);
                end
                n_checks++;
                if ({out_qos, out_type, out_src, out_tgt, out_data} !== m_out) begin
                    n_fail++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, out_data, m_out[FLIT_W-1:0]);
                end
                exp_port = (exp_port + 1) % N_IN;
            end
        end
        in_vld = '0;
    endtask

    task automatic test_qos_starve();
        int k, exp_port;
        do_reset();
        set_ch(1, 1'b1, GOOD, $urandom);
        set_ch(5, 1'b0, GOOD, $urandom);
        in_vld = 7'b0100010; k = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            refresh();
            if (c >= 1) begin
                exp_port = (k % (STARVE_LIM + 1) == STARVE_LIM) ? 5 : 1;
                n_checks++;
                if (out_vld !== 1'b1 || out_port !== PW'(exp_port)) begin
                    n_fail++; $display("FAIL qos_pattern k=%0d got vld=%b port=%0d exp port=%0d", k, out_vld, out_port, exp_port);
                end
                k++;
            end
        end
        in_vld = '0;
    endtask

    task automatic test_backpressure();
        int n_acc;
        logic [FLIT_W-1:0] held, exp_d;
        do_reset();
        exp_q.delete();
        out_rdy = 1'b0; n_acc = 0; held = '0;
        set_ch(0, 1'b0, GOOD, $urandom);
        in_vld = 7'b0000001;
        for (int c = 0; c < 10; c++) begin
            step();
            if (last_hs[0]) begin exp_q.push_back(in_data[FLIT_W-1:0]); n_acc++; end
            refresh();
            if (c == 1) held = out_data;
            if (c >= 1) begin
                n_checks++;
                if (out_vld !== 1'b1 || out_data !== held) begin
                    n_fail++; $display("FAIL bp_hold c=%0d got vld=%b data=%h exp data=%h", c, out_vld, out_data, held);
                end
            end
        end
        n_checks++; if (n_acc !== 3) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=3", n_acc); end
        n_checks++; if (in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_rdy got=%b exp=0", in_rdy[0]); end
        out_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_vld[0] = (c < 6);
            step();
            if (last_hs[0]) exp_q.push_back(in_data[FLIT_W-1:0]);
            refresh();
            if (got_vld) begin
                n_checks++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : ~got_data;
                if (got_data !== exp_d) begin n_fail++; $display("FAIL bp_order got=%h exp=%h", got_data, exp_d); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_lost got=%0d left exp=0", exp_q.size()); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_extra got vld=%b exp=0", out_vld); end
    endtask

    task automatic test_misroute();
        logic [ID_W-1:0] tg [5];
        logic [FLIT_W-1:0] exp_d;
        int k, n_out;
        tg = '{BAD, GOOD, BAD, GOOD, BAD};
        do_reset();
        exp_q.delete();
        k = 0; n_out = 0;
        set_ch(2, 1'b0, tg[0], $urandom);
        in_vld = 7'b0000100;
        for (int c = 0; c < 20; c++) begin
            step();
            if (last_hs[2]) begin
                if (tg[k] == GOOD) exp_q.push_back(in_data[2*FLIT_W +: FLIT_W]);
                k++;
                if (k < 5) set_ch(2, 1'b0, tg[k], $urandom);
                else       in_vld[2] = 1'b0;
            end
            if (got_vld) begin
                n_out++;
                n_checks++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : ~got_data;
                if (got_data !== exp_d || got_port !== 3'd2) begin
                    n_fail++; $display("FAIL mis_out got=%h port=%0d exp=%h port=2", got_data, got_port, exp_d);
                end
            end
        end
        n_checks++; if (n_out !== 2) begin n_fail++; $display("FAIL mis_count got=%0d exp=2", n_out); end
        n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL mis_err_cnt got=%0d exp=3", err_cnt); end
        n_checks++; if (err_misroute !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%b exp=1", err_misroute); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < N_IN; i++) set_ch(i, 1'($urandom), GOOD, $urandom);
        set_ch(6, 1'b0, BAD, $urandom);
        in_vld = 7'b1001011;
        for (int c = 0; c < 5; c++) begin step(); refresh(); end
        n_checks++;
        if (out_vld !== 1'b1 || err_misroute !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre got vld=%b err=%b exp 1/1", out_vld, err_misroute);
        end
        rst_n = 1'b0; in_vld = '0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if (out_vld !== 1'b0 || err_cnt !== 16'd0 || err_misroute !== 1'b0 || in_rdy !== 7'h00) begin
            n_fail++; $display("FAIL midrst_state got vld=%b cnt=%0d err=%b rdy=%h", out_vld, err_cnt, err_misroute, in_rdy);
        end
        out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_stale c=%0d got vld=%b exp=0", c, out_vld); end
        end
        n_checks++; if (in_rdy !== 7'h7F) begin n_fail++; $display("FAIL midrst_rdy got=%h exp=7f", in_rdy); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (!in_vld[i] || last_hs[i]) begin
                    in_vld[i] = ($urandom_range(0, 3) != 0);
                    set_ch(i, 1'($urandom), ($urandom_range(0, 7) == 0) ? BAD : GOOD, $urandom);
                end
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
            n_checks++; if (in_rdy !== m_rdy) begin n_fail++; $display("FAIL rnd_rdy c=%0d got=%h exp=%h", c, in_rdy, m_rdy); end
            n_checks++; if (out_vld !== m_vld) begin n_fail++; $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, out_vld, m_vld); end
            if (m_vld) begin
                n_checks++;
                if ({out_qos, out_type, out_src, out_tgt, out_data} !== m_out || out_port !== m_port) begin
                    n_fail++; $display("FAIL rnd_out c=%0d got=%h port=%0d exp=%h port=%0d", c, out_data, out_port, m_out[FLIT_W-1:0], m_port);
                end
            end
            n_checks++;
            if (err_cnt !== m_cnt || err_misroute !== m_err) begin
                n_fail++; $display("FAIL rnd_err c=%0d got=%0d/%b exp=%0d/%b", c, err_cnt, err_misroute, m_cnt, m_err);
            end
        end
        in_vld = '0;
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < N_IN; i++) set_ch(i, 1'($urandom), BAD, $urandom);
        in_vld = '1;
        for (int c = 0; c < 9400; c++) begin
            step();
            if (c == 100) begin
                n_checks++; if (err_cnt !== m_cnt) begin n_fail++; $display("FAIL sat_mid got=%0d exp=%0d", err_cnt, m_cnt); end
            end
        end
        n_checks++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got=%h exp=ffff", err_cnt); end
        n_checks++;
        if (out_vld !== 1'b0 || in_rdy !== 7'h7F) begin
            n_fail++; $display("FAIL sat_state got vld=%b rdy=%h exp 0/7f", out_vld, in_rdy);
        end
        in_vld = '0;
    endtask

    initial begin
        rst_n = 1'b0; in_vld = '0; out_rdy = 1'b0; in_qos = '0;
        in_type = '0; in_src = '0; in_tgt = '0; in_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_qos_starve();
        test_backpressure();
        test_misroute();
        test_mid_reset();
        test_random();
        test_err_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
